aes_fi_campaign_ctrl: RTL

Sequencer that drives one aes_128 core through a complete fault-injection campaign. For one key/plaintext pair it first runs a fault-free golden encryption. It then sweeps the injected fault over every row, column and bit of the state for a configured round/function, and classifies each run as detected, silent (corrupt but undetected), masked or timed out. It sits between a host or bench and the aes_128 core, replacing hand-driven reset/stimulus sequencing.

---
 rtl/aes_fi_campaign_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_fi_campaign_ctrl.sv
`default_nettype none
// ============================================================================
// aes_fi_campaign_ctrl -- golden run plus row/column/bit fault sweep of one aes_128 core
// Rev 1.0
// ============================================================================
module aes_fi_campaign_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64,
  parameter int BIT_MAX    = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] data,
  input  logic         cfg_mode_FI,
  input  logic [3:0]   cfg_func_FI,
  input  logic [3:0]   cfg_round_FI,
  input  logic [3:0]   cfg_round_stop_FI,
  output logic         busy,
  output logic         campaign_done,
  output logic         campaign_error,
  output logic         core_reset,
  output logic [127:0] core_key,
  output logic [127:0] core_data,
  output logic         core_en_FI,
  output logic         core_mode_FI,
  output logic [3:0]   core_func_FI,
  output logic [3:0]   core_round_FI,
  output logic [3:0]   core_round_stop_FI,
  output logic [1:0]   core_row_FI,
  output logic [1:0]   core_column_FI,
  output logic [3:0]   core_bit_index_FI,
  input  logic [127:0] core_ciphertext,
  input  logic         core_done,
  input  logic         core_fault_detected,
  input  logic [3:0]   core_fault_location,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_golden,
  output logic [1:0]   res_row,
  output logic [1:0]   res_column,
  output logic [3:0]   res_bit,
  output logic [127:0] res_ciphertext,
  output logic         res_detected,
  output logic [3:0]   res_location,
  output logic         res_corrupt,
  output logic         res_timeout,
  output logic [8:0]   cnt_detected,
  output logic [8:0]   cnt_silent,
  output logic [8:0]   cnt_masked,
  output logic [8:0]   cnt_timeout
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RCW-1:0] C_RST_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]  C_TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]     C_BIT_MAX    = 4'(BIT_MAX);
  localparam logic [8:0]     C_CNT_MAX    = 9'd511;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_EMIT = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [127:0]   r_key, r_data, r_ct, r_golden_ct;
  logic           r_mode, r_golden, r_det, r_timeout, r_error;
  logic [3:0]     r_func, r_round, r_stop, r_bit, r_loc;
  logic [1:0]     r_row, r_col;
  logic [RCW-1:0] r_rst_cnt;
  logic [TW-1:0]  r_timer;
  logic [8:0]     r_cnt_det, r_cnt_sil, r_cnt_mask, r_cnt_to;
  logic           w_done_seen, w_timer_exp, w_last, w_corrupt;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == C_CNT_MAX) ? v : v + 9'd1;
  endfunction

  // A done already high on the first RUN cycle is left over from the core's reset release.
  assign w_done_seen = core_done && (r_timer != '0);
  assign w_timer_exp = (r_timer == C_TIMER_LAST);
  assign w_last      = (r_row == 2'd3) && (r_col == 2'd3) && (r_bit == C_BIT_MAX);
  assign w_corrupt   = !r_golden && !r_timeout && (r_ct != r_golden_ct);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    busy          = 1'b0;
    campaign_done = 1'b0;
    core_reset    = 1'b1;
    core_en_FI    = 1'b0;
    res_valid     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RST;
      S_RST: begin
        busy       = 1'b1;
        core_en_FI = !r_golden;
        if (r_rst_cnt == C_RST_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        core_en_FI = !r_golden;
        if (w_done_seen || w_timer_exp) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = (r_golden && r_timeout) ? S_DONE : S_NEXT;
      end
      S_NEXT: begin
        busy        = 1'b1;
        w_state_nxt = (!r_golden && w_last) ? S_DONE : S_RST;
      end
      S_DONE: begin
        campaign_done = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_key       <= '0;
      r_data      <= '0;
      r_mode      <= 1'b0;
      r_func      <= '0;
      r_round     <= '0;
      r_stop      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_bit       <= '0;
      r_golden    <= 1'b0;
      r_rst_cnt   <= '0;
      r_timer     <= '0;
      r_ct        <= '0;
      r_golden_ct <= '0;
      r_det       <= 1'b0;
      r_loc       <= '0;
      r_timeout   <= 1'b0;
      r_error     <= 1'b0;
      r_cnt_det   <= '0;
      r_cnt_sil   <= '0;
      r_cnt_mask  <= '0;
      r_cnt_to    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_key      <= key;
          r_data     <= data;
          r_mode     <= cfg_mode_FI;
          r_func     <= cfg_func_FI;
          r_round    <= cfg_round_FI;
          r_stop     <= cfg_round_stop_FI;
          r_row      <= '0;
          r_col      <= '0;
          r_bit      <= '0;
          r_golden   <= 1'b1;
          r_rst_cnt  <= '0;
          r_error    <= 1'b0;
          r_cnt_det  <= '0;
          r_cnt_sil  <= '0;
          r_cnt_mask <= '0;
          r_cnt_to   <= '0;
        end
        S_RST: begin
          r_rst_cnt <= r_rst_cnt + 1'b1;
          r_timer   <= '0;
          r_timeout <= 1'b0;
        end
        S_RUN: begin
          r_rst_cnt <= '0;
          r_timer   <= r_timer + 1'b1;
          if (w_done_seen) begin
            r_ct  <= core_ciphertext;
            r_det <= core_fault_detected;
            r_loc <= core_fault_location;
          end else if (w_timer_exp) begin
            r_timeout <= 1'b1;
            r_ct      <= '0;
            r_det     <= 1'b0;
            r_loc     <= '0;
          end
        end
        S_EMIT: if (res_ready) begin
          if (r_golden) begin
            if (r_timeout) r_error     <= 1'b1;
            else           r_golden_ct <= r_ct;
          end else if (r_timeout)  r_cnt_to   <= sat_inc(r_cnt_to);
          else if (r_det)          r_cnt_det  <= sat_inc(r_cnt_det);
          else if (w_corrupt)      r_cnt_sil  <= sat_inc(r_cnt_sil);
          else                     r_cnt_mask <= sat_inc(r_cnt_mask);
        end
        S_NEXT: begin
          // The golden run occupies coordinate (0,0,0) without consuming it.
          if (r_golden) begin
            r_golden <= 1'b0;
          end else if (r_bit == C_BIT_MAX) begin
            r_bit <= '0;
            r_col <= r_col + 1'b1;
            if (r_col == 2'd3) r_row <= r_row + 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign campaign_error     = r_error;
  assign core_key           = r_key;
  assign core_data          = r_data;
  assign core_mode_FI       = r_mode;
  assign core_func_FI       = r_func;
  assign core_round_FI      = r_round;
  assign core_round_stop_FI = r_stop;
  assign core_row_FI        = r_row;
  assign core_column_FI     = r_col;
  assign core_bit_index_FI  = r_bit;
  assign res_golden         = r_golden;
  assign res_row            = r_row;
  assign res_column         = r_col;
  assign res_bit            = r_bit;
  assign res_ciphertext     = r_ct;
  assign res_detected       = r_det;
  assign res_location       = r_loc;
  assign res_corrupt        = w_corrupt;
  assign res_timeout        = r_timeout;
  assign cnt_detected       = r_cnt_det;
  assign cnt_silent         = r_cnt_sil;
  assign cnt_masked         = r_cnt_mask;
  assign cnt_timeout        = r_cnt_to;

endmodule
`default_nettype wire
